// File: rtl/gam_node_mem_arbiter_pkg.sv
// gam_node_mem_arbiter_pkg: shared types and constants for the GAM node memory arbiter.
package gam_node_mem_arbiter_pkg;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} RD_WR_T;

    typedef enum logic [2:0] {
        BANK_X = 3'd0,
        BANK_C = 3'd1,
        BANK_W = 3'd2,
        BANK_T = 3'd3,
        BANK_M = 3'd4
    } bank_sel_T;

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} arb_state_T;

    localparam int REQ_MEM   = 0;
    localparam int REQ_ASSOC = 1;
    localparam int REQ_HOST  = 2;
    localparam int NUM_BANKS = 5;

    // Encodings past BANK_M select nothing.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_sel_T b);
        return (b <= BANK_M) ? NUM_BANKS'(1) << b : '0;
    endfunction

endpackage

// File: rtl/gam_node_mem_arbiter_rr_picker.sv
// gam_rr_picker: combinational round-robin pick of the first set request at or after ptr_i.
module gam_rr_picker #(
    parameter int N = 3
) (
    input  logic [N-1:0]                   req_i,
    input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr_i,
    output logic [N-1:0]                   pick_o,
    output logic                           any_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] j;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[j]) begin
                pick_o[j] = 1'b1;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gam_node_mem_arbiter.sv
// gam_node_mem_arbiter: round-robin arbiter with bounded locked bursts over the GAM node memory banks.
module gam_node_mem_arbiter
    import gam_node_mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ-1:0]               lock_i,
    input  bank_sel_T [N_REQ-1:0]          bank_i,
    input  RD_WR_T [N_REQ-1:0]             rd_wr_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]               gnt_o,
    output logic [N_REQ-1:0]               rvalid_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           X_c_o,
    output logic                           C_c_o,
    output logic                           W_c_o,
    output logic                           T_c_o,
    output logic                           M_c_o,
    output RD_WR_T                         RD_WR_c_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic [DATA_W-1:0]              mem_rdata_i,
    output logic                           busy_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_T              state_q, state_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d, elig, pick, rvalid_q, rvalid_d;
    logic [IW-1:0]           idx_q, idx_d, rr_q, rr_d, nxt_ptr, ptr_sel, pick_idx, tag_q, tag_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]    ce_q, ce_d;
    RD_WR_T                  rw_q, rw_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    tag_v_q, tag_v_d, any, beat, rel, arb;

    gam_rr_picker #(.N(N_REQ)) u_pick (
        .req_i  (elig),
        .ptr_i  (ptr_sel),
        .pick_o (pick),
        .any_o  (any)
    );

    always_comb begin
        nxt_ptr  = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        beat     = (state_q == GRANTED) && req_i[idx_q];
        rel      = (state_q == GRANTED) && (!req_i[idx_q] ||
                   (beat && (!lock_i[idx_q] || cnt_q == CW'(MAX_BURST - 1))));
        arb      = (state_q == IDLE) || rel;
        ptr_sel  = rel ? nxt_ptr : rr_q;
        // A non-locked beat consumes the request that carried it; it must not win again off the same req.
        elig     = (beat && !lock_i[idx_q]) ? req_i & ~gnt_q : req_i;
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++)
            if (pick[k]) pick_idx = IW'(k);
        state_d  = arb ? (any ? GRANTED : IDLE) : state_q;
        gnt_d    = arb ? (any ? pick : '0) : gnt_q;
        idx_d    = (arb && any) ? pick_idx : idx_q;
        rr_d     = rel ? nxt_ptr : rr_q;
        cnt_d    = rel ? '0 : beat ? cnt_q + CW'(1) : cnt_q;
        ce_d     = beat ? bank_onehot(bank_i[idx_q]) : '0;
        rw_d     = beat ? rd_wr_i[idx_q] : rw_q;
        addr_d   = beat ? addr_i[idx_q] : addr_q;
        wdata_d  = beat ? wdata_i[idx_q] : wdata_q;
        tag_v_d  = beat && (rd_wr_i[idx_q] == READ);
        tag_d    = beat ? idx_q : tag_q;
        rvalid_d = tag_v_q ? N_REQ'(1) << tag_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            ce_q     <= '0;
            rw_q     <= READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            tag_v_q  <= 1'b0;
            tag_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tag_v_q  <= tag_v_d;
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = (|rvalid_q) ? mem_rdata_i : '0;
    assign {M_c_o, T_c_o, W_c_o, C_c_o, X_c_o} = ce_q;
    assign RD_WR_c_o   = rw_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q == GRANTED);

endmodule
